// File: rtl/int_closest_hit.sv
// -----------------------------------------------------------------------------
// int_closest_hit
//
// Purpose
//   Reduces a stream of ray/triangle intersection results to one nearest-hit
//   record per ray. Each ray owns a slot (selected by in_ray_id). The slot
//   holds the best candidate seen so far. The beat flagged in_last merges
//   its candidate with the slot and pushes the result into a
//   first-word-fall-through output FIFO. Beats of different rays may
//   interleave freely.
//
// Optional feature (compile-time macro INT_SHADOW_EN)
//   Adds the in_shadow input. A shadow ray only counts hits with t < 1.0
//   (hit & t_int_lt1). It reports on its first qualifying hit and drops the
//   rest of its beats. When the macro is undefined, in_shadow does not exist,
//   t_int_lt1 is ignored, and every ray is a nearest-hit ray.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   in_valid/in_ready input handshake (in_ready = !fifo_full)
//   in_ray_id         ray slot tag
//   in_tri_id         triangle tested by this beat
//   in_last           final triangle for this ray
//   hit, t_int, uv    intersection result (t_int is IEEE-754 single, positive)
//   t_int_lt1         t_int < 1.0 (used only by shadow rays)
//   in_shadow         shadow-ray flag (INT_SHADOW_EN builds only)
//   out_valid/out_ready  output handshake (FWFT FIFO head)
//   out_ray_id, out_hit, out_tri_id, out_t_int, out_uv  nearest-hit result
// -----------------------------------------------------------------------------
module int_closest_hit #(
  parameter int NUM_RAYS = 8,
  parameter int TRI_ID_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [$clog2(NUM_RAYS)-1:0] in_ray_id,
  input  logic [TRI_ID_W-1:0]         in_tri_id,
  input  logic                        in_last,
  input  logic                        hit,
  input  logic [31:0]                 t_int,
  input  logic [63:0]                 uv,
  input  logic                        t_int_lt1,
`ifdef INT_SHADOW_EN
  input  logic                        in_shadow,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(NUM_RAYS)-1:0] out_ray_id,
  output logic                        out_hit,
  output logic [TRI_ID_W-1:0]         out_tri_id,
  output logic [31:0]                 out_t_int,
  output logic [63:0]                 out_uv
);

  localparam int RID_W = $clog2(NUM_RAYS);
  localparam int CNT_W = $clog2(NUM_RAYS + 1);
  // +infinity: the "no hit" distance, and larger than any finite positive t.
  localparam logic [31:0] T_INF = 32'h7F80_0000;

  // Positive IEEE-754 singles order the same way as their magnitude bits
  // taken as unsigned integers, so no float compare is needed.
  function automatic logic t_closer(input logic [30:0] cand_mag,
                                    input logic [30:0] best_mag);
    return cand_mag < best_mag;
  endfunction

  // The FIFO pointers wrap at NUM_RAYS, which need not be a power of two.
  function automatic logic [RID_W-1:0] ptr_inc(input logic [RID_W-1:0] p);
    return (p == RID_W'(NUM_RAYS - 1)) ? '0 : p + RID_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Slot state. The control bits are reset. The best-candidate data is not
  // reset, because it is only read while the slot is active.
  // ---------------------------------------------------------------------------
  logic [NUM_RAYS-1:0] active_q, active_d;
  logic                best_hit_q [NUM_RAYS];
  logic [31:0]         best_t_q   [NUM_RAYS];
  logic [TRI_ID_W-1:0] best_tri_q [NUM_RAYS];
  logic [63:0]         best_uv_q  [NUM_RAYS];

  logic accept;
  logic qual_hit;   // the beat counts as a hit for this ray's kind
  logic early;      // shadow ray found an occluder: report now
  logic slot_act;
  logic slot_done;
  logic take;       // the candidate beats the slot's current best
  logic push;
  logic pop;
  logic slot_we;

  logic                m_hit;
  logic [31:0]         m_t;
  logic [TRI_ID_W-1:0] m_tri;
  logic [63:0]         m_uv;

  // FIFO state
  logic [RID_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full_q, full_d;
  logic [RID_W-1:0]    fifo_rid_q [NUM_RAYS];
  logic                fifo_hit_q [NUM_RAYS];
  logic [TRI_ID_W-1:0] fifo_tri_q [NUM_RAYS];
  logic [31:0]         fifo_t_q   [NUM_RAYS];
  logic [63:0]         fifo_uv_q  [NUM_RAYS];

  // in_ready comes from the registered full flag. A full FIFO therefore
  // never sees a push in the cycle it pops.
  assign in_ready  = !full_q;
  assign out_valid = (count_q != '0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign slot_act  = active_q[in_ray_id];

`ifdef INT_SHADOW_EN
  logic [NUM_RAYS-1:0] done_q, done_d;

  assign qual_hit  = hit & (!in_shadow | t_int_lt1);
  assign early     = in_shadow & qual_hit;
  assign slot_done = done_q[in_ray_id];
`else
  logic unused_t_int_lt1;

  assign unused_t_int_lt1 = t_int_lt1;
  assign qual_hit  = hit;
  assign early     = 1'b0;
  assign slot_done = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Merge of the incoming beat with the slot's best. An inactive slot acts
  // as an empty "miss" record, so a first beat and a single-beat ray use
  // the same path. A strict less-than keeps the earlier triangle when the
  // distances are equal.
  // ---------------------------------------------------------------------------
  always_comb begin
    take  = qual_hit & (!slot_act |
                        t_closer(t_int[30:0], best_t_q[in_ray_id][30:0]));
    m_hit = 1'b0;
    m_t   = T_INF;
    m_tri = '0;
    m_uv  = '0;
    if (take) begin
      m_hit = 1'b1;
      m_t   = t_int;
      m_tri = in_tri_id;
      m_uv  = uv;
    end else if (slot_act) begin
      m_hit = best_hit_q[in_ray_id];
      m_t   = best_t_q[in_ray_id];
      m_tri = best_tri_q[in_ray_id];
      m_uv  = best_uv_q[in_ray_id];
    end
  end

  // A finished shadow slot swallows beats, and its in_last only frees it.
  assign push    = accept & !slot_done & (in_last | early);
  assign slot_we = accept & !slot_done & !in_last;

  always_comb begin
    active_d = active_q;
`ifdef INT_SHADOW_EN
    done_d   = done_q;
`endif
    if (accept) begin
      if (in_last) begin
        active_d[in_ray_id] = 1'b0;
`ifdef INT_SHADOW_EN
        done_d[in_ray_id]   = 1'b0;
`endif
      end else begin
        active_d[in_ray_id] = 1'b1;
`ifdef INT_SHADOW_EN
        if (early) begin
          done_d[in_ray_id] = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= '0;
    end else begin
      active_q <= active_d;
    end
  end

`ifdef INT_SHADOW_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= '0;
    end else begin
      done_q <= done_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (slot_we) begin
      best_hit_q[in_ray_id] <= m_hit;
      best_t_q[in_ray_id]   <= m_t;
      best_tri_q[in_ray_id] <= m_tri;
      best_uv_q[in_ray_id]  <= m_uv;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (registered storage, head shown combinationally)
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    full_d  = (count_d == CNT_W'(NUM_RAYS));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rid_q[wr_ptr_q] <= in_ray_id;
      fifo_hit_q[wr_ptr_q] <= m_hit;
      fifo_tri_q[wr_ptr_q] <= m_tri;
      fifo_t_q[wr_ptr_q]   <= m_t;
      fifo_uv_q[wr_ptr_q]  <= m_uv;
    end
  end

  // Outputs are forced to zero while the FIFO is empty. The FIFO storage
  // has no reset, so this gating is what makes the outputs zero during and
  // after reset.
  always_comb begin
    out_ray_id = '0;
    out_hit    = 1'b0;
    out_tri_id = '0;
    out_t_int  = '0;
    out_uv     = '0;
    if (out_valid) begin
      out_ray_id = fifo_rid_q[rd_ptr_q];
      out_hit    = fifo_hit_q[rd_ptr_q];
      out_tri_id = fifo_tri_q[rd_ptr_q];
      out_t_int  = fifo_t_q[rd_ptr_q];
      out_uv     = fifo_uv_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_int_closest_hit.sv
// -----------------------------------------------------------------------------
// tb_int_closest_hit
//
// Directed bench for int_closest_hit (NUM_RAYS=8, TRI_ID_W=16). The expected
// results below are worked out by hand from the beats each test sends.
// When INT_SHADOW_EN is defined, the shadow-ray cases are compiled in too.
// -----------------------------------------------------------------------------
module tb_int_closest_hit;

  localparam logic [31:0] T_INF = 32'h7F80_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_ray_id;
  logic [15:0] in_tri_id;
  logic        in_last;
  logic        hit;
  logic [31:0] t_int;
  logic [63:0] uv;
  logic        t_int_lt1;
  logic        in_shadow;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_ray_id;
  logic        out_hit;
  logic [15:0] out_tri_id;
  logic [31:0] out_t_int;
  logic [63:0] out_uv;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  int_closest_hit #(.NUM_RAYS(8), .TRI_ID_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ray_id (in_ray_id),
    .in_tri_id (in_tri_id),
    .in_last   (in_last),
    .hit       (hit),
    .t_int     (t_int),
    .uv        (uv),
    .t_int_lt1 (t_int_lt1),
`ifdef INT_SHADOW_EN
    .in_shadow (in_shadow),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ray_id(out_ray_id),
    .out_hit   (out_hit),
    .out_tri_id(out_tri_id),
    .out_t_int (out_t_int),
    .out_uv    (out_uv)
  );

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  // Present one beat for one clock. Call it just after a rising edge. It
  // returns just after the edge that samples the beat.
  task automatic beat(input logic [2:0] id, input logic [15:0] tid,
                      input logic [31:0] t, input logic [63:0] u,
                      input logic h, input logic last,
                      input logic lt1, input logic sh);
    in_valid  = 1'b1;
    in_ray_id = id;
    in_tri_id = tid;
    t_int     = t;
    uv        = u;
    hit       = h;
    in_last   = last;
    t_int_lt1 = lt1;
    in_shadow = sh;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  // Wait (bounded) for the FIFO head, then compare every field.
  task automatic expect_res(input string tag, input logic [2:0] id,
                            input logic h, input logic [15:0] tid,
                            input logic [31:0] t, input logic [63:0] u);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk({tag, "_vld"}, 64'(out_valid),  64'(1));
    chk({tag, "_rid"}, 64'(out_ray_id), 64'(id));
    chk({tag, "_hit"}, 64'(out_hit),    64'(h));
    chk({tag, "_tri"}, 64'(out_tri_id), 64'(tid));
    chk({tag, "_t"},   64'(out_t_int),  64'(t));
    chk({tag, "_uv"},  out_uv,          u);
  endtask

  task automatic expect_empty(input string tag);
    @(negedge clk);
    chk({tag, "_empty"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ray_id = '0; in_tri_id = '0;
    in_last = 1'b0; hit = 1'b0; t_int = '0; uv = '0; t_int_lt1 = 1'b0;
    in_shadow = 1'b0; out_ready = 1'b0;

    // Reset state, checked before any clock edge (asynchronous reset).
    #2;
    chk("rst_in_ready",  64'(in_ready),   64'(1));
    chk("rst_out_valid", 64'(out_valid),  64'(0));
    chk("rst_out_rid",   64'(out_ray_id), 64'(0));
    chk("rst_out_hit",   64'(out_hit),    64'(0));
    chk("rst_out_tri",   64'(out_tri_id), 64'(0));
    chk("rst_out_t",     64'(out_t_int),  64'(0));
    chk("rst_out_uv",    out_uv,          64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Three hits on ray 2. The middle one (t=1.5, tri 9) is the nearest.
    out_ready = 1'b1;
    beat(3'd2, 16'd5, 32'h4040_0000, 64'h0000_0005_0000_0005, 1'b1, 1'b0, 1'b0, 1'b0);
    beat(3'd2, 16'd9, 32'h3FC0_0000, 64'h0000_0009_0000_0009, 1'b1, 1'b0, 1'b0, 1'b0);
    beat(3'd2, 16'd4, 32'h4000_0000, 64'h0000_0004_0000_0004, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_res("r2_min", 3'd2, 1'b1, 16'd9, 32'h3FC0_0000, 64'h0000_0009_0000_0009);
    expect_empty("r2_pop");

    // Ray 0 with two misses: reported as a miss, with t = +inf and zero fields.
    beat(3'd0, 16'd21, 32'h3F00_0000, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(3'd0, 16'd22, 32'h3E00_0000, 64'h5555_6666_7777_8888, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_res("r0_miss", 3'd0, 1'b0, 16'd0, T_INF, 64'd0);
    expect_empty("r0_pop");

    // Equal distances: the earlier triangle (tri 1) is kept.
    beat(3'd4, 16'd1, 32'h3F80_0000, 64'hAAAA_0000_0000_0001, 1'b1, 1'b0, 1'b0, 1'b0);
    beat(3'd4, 16'd2, 32'h3F80_0000, 64'hBBBB_0000_0000_0002, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_res("r4_tie", 3'd4, 1'b1, 16'd1, 32'h3F80_0000, 64'hAAAA_0000_0000_0001);
    expect_empty("r4_pop");

    // Interleaved rays 1 and 3. Ray 3 finishes first, so it is reported first.
    out_ready = 1'b0;
    beat(3'd1, 16'd10, 32'h4000_0000, 64'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    beat(3'd3, 16'd30, 32'h40A0_0000, 64'd30, 1'b1, 1'b0, 1'b0, 1'b0);
    beat(3'd1, 16'd11, 32'h3F80_0000, 64'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    beat(3'd3, 16'd31, 32'h4080_0000, 64'd31, 1'b1, 1'b0, 1'b0, 1'b0);
    beat(3'd3, 16'd32, 32'h40C0_0000, 64'd32, 1'b1, 1'b1, 1'b0, 1'b0);
    beat(3'd1, 16'd12, 32'h3FC0_0000, 64'd12, 1'b1, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b1;
    expect_res("il_r3", 3'd3, 1'b1, 16'd31, 32'h4080_0000, 64'd31);
    expect_res("il_r1", 3'd1, 1'b1, 16'd11, 32'h3F80_0000, 64'd11);
    expect_empty("il_pop");

    // A push and a pop in the same cycle at occupancy 1 leave the count at 1.
    out_ready = 1'b0;
    beat(3'd0, 16'd40, 32'h3F80_0000, 64'd40, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_res("pp_r0", 3'd0, 1'b1, 16'd40, 32'h3F80_0000, 64'd40);
    out_ready = 1'b1;
    beat(3'd1, 16'd41, 32'h4000_0000, 64'd41, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_res("pp_r1", 3'd1, 1'b1, 16'd41, 32'h4000_0000, 64'd41);
    expect_empty("pp_pop");

    // Fill the FIFO with 8 single-beat rays (ray 5 is a miss). in_ready
    // drops only after the 8th push, and a 9th beat is refused.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat(3'(i), 16'(100 + i), 32'h3F80_0000 + 32'(i), 64'hA0 + 64'(i),
           (i != 5), 1'b1, 1'b0, 1'b0);
      chk($sformatf("fill_rdy%0d", i), 64'(in_ready), 64'(i < 7));
    end
    beat(3'd2, 16'd999, 32'h3000_0000, 64'd999, 1'b1, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_res($sformatf("drain%0d", i), 3'(i), (i != 5),
                 (i != 5) ? 16'(100 + i) : 16'd0,
                 (i != 5) ? 32'h3F80_0000 + 32'(i) : T_INF,
                 (i != 5) ? 64'hA0 + 64'(i) : 64'd0);
    end
    expect_empty("drain_end");
    chk("drain_rdy", 64'(in_ready), 64'(1));

    // Asynchronous reset with one result queued and ray 6 half done: both
    // are lost, and ray 6 starts over from an empty slot.
    @(posedge clk); #1;
    out_ready = 1'b0;
    beat(3'd7, 16'd77, 32'h4000_0000, 64'd77, 1'b1, 1'b1, 1'b0, 1'b0);
    beat(3'd6, 16'd66, 32'h3F80_0000, 64'd66, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_vld", 64'(out_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("arst_vld", 64'(out_valid),  64'(0));
    chk("arst_rdy", 64'(in_ready),   64'(1));
    chk("arst_tri", 64'(out_tri_id), 64'(0));
    chk("arst_t",   64'(out_t_int),  64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    beat(3'd6, 16'd67, 32'h4040_0000, 64'd67, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_res("r6_lost", 3'd6, 1'b0, 16'd0, T_INF, 64'd0);
    expect_empty("r6_pop");

`ifdef INT_SHADOW_EN
    // Shadow ray 5: the first beat occludes, so it is reported immediately.
    // Beats 2 and 3 add nothing.
    @(posedge clk); #1;
    out_ready = 1'b0;
    beat(3'd5, 16'd7, 32'h3F00_0000, 64'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("sh_early_vld", 64'(out_valid),  64'(1));
    chk("sh_early_tri", 64'(out_tri_id), 64'(7));
    @(posedge clk); #1;
    beat(3'd5, 16'd8, 32'h3E80_0000, 64'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    beat(3'd5, 16'd9, 32'h3E00_0000, 64'd9, 1'b0, 1'b1, 1'b0, 1'b1);
    out_ready = 1'b1;
    expect_res("sh_r5", 3'd5, 1'b1, 16'd7, 32'h3F00_0000, 64'd7);
    expect_empty("sh_drop1");
    expect_empty("sh_drop2");
    // The slot is free again, and a nearest-hit ray can reuse it.
    @(posedge clk); #1;
    beat(3'd5, 16'd10, 32'h4000_0000, 64'd10, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_res("sh_reuse", 3'd5, 1'b1, 16'd10, 32'h4000_0000, 64'd10);
    // A shadow hit beyond t=1.0 does not count as an occluder.
    @(posedge clk); #1;
    beat(3'd5, 16'd11, 32'h3FC0_0000, 64'd11, 1'b1, 1'b1, 1'b0, 1'b1);
    expect_res("sh_far", 3'd5, 1'b0, 16'd0, T_INF, 64'd0);
    expect_empty("sh_end");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
